// File: rtl/aurora_sup_pkg.sv
// +----------------------------------------------------------------------+
// | aurora_sup_pkg : shared FSM state type and timer sizing helper        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package aurora_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PMA_INIT = 3'd1,
    ST_RESET_PB = 3'd2,
    ST_WAIT_UP  = 3'd3,
    ST_READY    = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  // One spare bit above the largest tick count keeps the terminal compare in range.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aurora_sup_err_cnt.sv
// +----------------------------------------------------------------------+
// | aurora_sup_err_cnt : saturating event counter with clear priority     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module aurora_sup_err_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/aurora_link_supervisor.sv
// +----------------------------------------------------------------------+
// | aurora_link_supervisor : Aurora reset sequencing, link watch, retries |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module aurora_link_supervisor
  import aurora_sup_pkg::*;
#(
  parameter int CH_CNT         = 3,
  parameter int LANE_CNT       = 2,
  parameter int PMA_INIT_TICKS = 1024,
  parameter int RESET_PB_TICKS = 128,
  parameter int UP_TIMEOUT     = 1048576,
  parameter int RETRY_MAX      = 7,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [CH_CNT-1:0]                    channel_up,
  input  logic [CH_CNT-1:0][LANE_CNT-1:0]      lane_up,
  input  logic [CH_CNT-1:0]                    hard_err,
  input  logic [CH_CNT-1:0]                    soft_err,
  input  logic                                 err_clear,
  output logic                                 pma_init,
  output logic                                 reset_pb,
  output logic                                 link_ready,
  output logic                                 link_fail,
  output logic [2:0]                           state,
  output logic [7:0]                           retry_cnt,
  output logic                                 lanes_up,
  output logic [CH_CNT-1:0][ERR_CNT_W-1:0]     soft_err_cnt,
  output logic [CH_CNT-1:0][ERR_CNT_W-1:0]     hard_err_cnt
);

  localparam int              c_tmr_w    = timer_width(PMA_INIT_TICKS, RESET_PB_TICKS, UP_TIMEOUT);
  localparam logic [c_tmr_w-1:0] c_pma_last = c_tmr_w'(PMA_INIT_TICKS - 1);
  localparam logic [c_tmr_w-1:0] c_rpb_last = c_tmr_w'(RESET_PB_TICKS - 1);
  localparam logic [c_tmr_w-1:0] c_up_last  = c_tmr_w'(UP_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [c_tmr_w-1:0]   timer_q, timer_d;
  logic [7:0]           retry_q, retry_d;
  logic                 pma_init_q, reset_pb_q, link_ready_q, link_fail_q, lanes_up_q;
  logic                 w_retry;
  logic                 w_cnt_en;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timer_d = timer_q;
    w_retry = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_PMA_INIT;
      ST_PMA_INIT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == c_pma_last) state_d = ST_RESET_PB;
      end
      ST_RESET_PB: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == c_rpb_last) state_d = ST_WAIT_UP;
      end
      ST_WAIT_UP: begin
        timer_d = timer_q + 1'b1;
        // A hard error in the same cycle as full link-up still forces a retry.
        if (|hard_err)                 w_retry = 1'b1;
        else if (&channel_up)          state_d = ST_READY;
        else if (timer_q == c_up_last) w_retry = 1'b1;
      end
      ST_READY: begin
        if (!(&channel_up) || (|hard_err)) w_retry = 1'b1;
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase

    if (w_retry) begin
      if ((RETRY_MAX != 0) && (32'(retry_q) == RETRY_MAX)) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_PMA_INIT;
        if (retry_q != 8'hFF) retry_d = retry_q + 1'b1;
      end
    end

    if (!enable)             state_d = ST_IDLE;
    if (state_d == ST_IDLE)  retry_d = '0;
    if ((state_d != state_q) || (state_d == ST_IDLE)) timer_d = '0;
  end

  // Reset/ready/fail outputs track the next state so they move with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      pma_init_q   <= 1'b1;
      reset_pb_q   <= 1'b1;
      link_ready_q <= 1'b0;
      link_fail_q  <= 1'b0;
      lanes_up_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      pma_init_q   <= (state_d == ST_IDLE) || (state_d == ST_PMA_INIT) || (state_d == ST_FAIL);
      reset_pb_q   <= (state_d == ST_IDLE) || (state_d == ST_PMA_INIT) ||
                      (state_d == ST_RESET_PB) || (state_d == ST_FAIL);
      link_ready_q <= (state_d == ST_READY);
      link_fail_q  <= (state_d == ST_FAIL);
      lanes_up_q   <= &lane_up;
    end
  end

  assign w_cnt_en = (state_q == ST_WAIT_UP) || (state_q == ST_READY);

  for (genvar ch = 0; ch < CH_CNT; ch++) begin : g_ch_cnt
    aurora_sup_err_cnt #(.W(ERR_CNT_W)) u_soft (
      .clk   (clk),
      .reset (reset),
      .en    (w_cnt_en),
      .inc   (soft_err[ch]),
      .clr   (err_clear),
      .cnt   (soft_err_cnt[ch])
    );
    aurora_sup_err_cnt #(.W(ERR_CNT_W)) u_hard (
      .clk   (clk),
      .reset (reset),
      .en    (w_cnt_en),
      .inc   (hard_err[ch]),
      .clr   (err_clear),
      .cnt   (hard_err_cnt[ch])
    );
  end

  assign pma_init   = pma_init_q;
  assign reset_pb   = reset_pb_q;
  assign link_ready = link_ready_q;
  assign link_fail  = link_fail_q;
  assign state      = state_q;
  assign retry_cnt  = retry_q;
  assign lanes_up   = lanes_up_q;

endmodule

`default_nettype wire

// File: tb/tb_aurora_link_supervisor.sv
// +----------------------------------------------------------------------+
// | tb_aurora_link_supervisor : directed + random bench with ref model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_aurora_link_supervisor;

  localparam int CH  = 2;
  localparam int LN  = 2;
  localparam int PMA = 8;
  localparam int RPB = 4;
  localparam int UPT = 32;
  localparam int RM  = 2;
  localparam int W   = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic reset, enable, err_clear;
  logic [CH-1:0] channel_up, hard_err, soft_err;
  logic [CH-1:0][LN-1:0] lane_up;
  logic pma_init, reset_pb, link_ready, link_fail, lanes_up;
  logic [2:0] state;
  logic [7:0] retry_cnt;
  logic [CH-1:0][W-1:0] soft_err_cnt, hard_err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase number, cycles spent in phase, retries, counters.
  int m_st, m_age, m_retry;
  int m_soft[CH];
  int m_hard[CH];
  bit m_lanes;

  int n_pma, n_rpb, n_wait, exp_h;

  aurora_link_supervisor #(
    .CH_CNT(CH), .LANE_CNT(LN), .PMA_INIT_TICKS(PMA), .RESET_PB_TICKS(RPB),
    .UP_TIMEOUT(UPT), .RETRY_MAX(RM), .ERR_CNT_W(W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .channel_up(channel_up),
    .lane_up(lane_up), .hard_err(hard_err), .soft_err(soft_err),
    .err_clear(err_clear), .pma_init(pma_init), .reset_pb(reset_pb),
    .link_ready(link_ready), .link_fail(link_fail), .state(state),
    .retry_cnt(retry_cnt), .lanes_up(lanes_up), .soft_err_cnt(soft_err_cnt),
    .hard_err_cnt(hard_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_retry = 0; m_lanes = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_soft[c] = 0;
      m_hard[c] = 0;
    end
  endtask

  task automatic model_next();
    int nst;
    bit rty, cnt_on;
    cnt_on = (m_st == 3) || (m_st == 4);
    for (int c = 0; c < CH; c++) begin
      if (err_clear) begin
        m_soft[c] = 0;
        m_hard[c] = 0;
      end else if (cnt_on) begin
        if (soft_err[c]) m_soft[c] = (m_soft[c] < SAT) ? m_soft[c] + 1 : SAT;
        if (hard_err[c]) m_hard[c] = (m_hard[c] < SAT) ? m_hard[c] + 1 : SAT;
      end
    end
    m_lanes = &lane_up;
    rty = 1'b0;
    nst = m_st;
    case (m_st)
      0: nst = 1;
      1: if (m_age + 1 >= PMA) nst = 2;
      2: if (m_age + 1 >= RPB) nst = 3;
      3: begin
        if (|hard_err)              rty = 1'b1;
        else if (&channel_up)       nst = 4;
        else if (m_age + 1 >= UPT)  rty = 1'b1;
      end
      4: if (!(&channel_up) || (|hard_err)) rty = 1'b1;
      default: nst = m_st;
    endcase
    if (rty) begin
      if (RM != 0 && m_retry == RM) nst = 5;
      else begin
        nst = 1;
        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      end
    end
    if (!enable) nst = 0;
    if (nst == 0) m_retry = 0;
    m_age = (nst != m_st) ? 0 : m_age + 1;
    m_st = nst;
  endtask

  task automatic check_all();
    chk("state",      32'(state),      m_st);
    chk("pma_init",   32'(pma_init),   (m_st == 0 || m_st == 1 || m_st == 5) ? 1 : 0);
    chk("reset_pb",   32'(reset_pb),   (m_st <= 2 || m_st == 5) ? 1 : 0);
    chk("link_ready", 32'(link_ready), (m_st == 4) ? 1 : 0);
    chk("link_fail",  32'(link_fail),  (m_st == 5) ? 1 : 0);
    chk("retry_cnt",  32'(retry_cnt),  m_retry);
    chk("lanes_up",   32'(lanes_up),   32'(m_lanes));
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("soft_cnt%0d", c), 32'(soft_err_cnt[c]), m_soft[c]);
      chk($sformatf("hard_cnt%0d", c), 32'(hard_err_cnt[c]), m_hard[c]);
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_lanes();
    lane_up = ($urandom_range(3) == 0) ? 4'($urandom) : '1;
  endtask

  task automatic wait_model(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && m_st != target; i++) begin
      rand_lanes();
      tick();
    end
    chk(tag, 32'(state), target);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; err_clear = 1'b0;
    channel_up = '0; hard_err = '0; soft_err = '0; lane_up = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_pma_init", 32'(pma_init), 1);
    chk("rst_reset_pb", 32'(reset_pb), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Nominal bring-up, link reported up from cycle 20.
    enable = 1'b1;
    n_pma = 0; n_rpb = 0;
    for (int c = 1; c <= 20; c++) begin
      rand_lanes();
      soft_err = ($urandom_range(7) == 0) ? 2'($urandom) : '0;
      tick();
      if (state == 3'd1) n_pma++;
      if (state == 3'd2) n_rpb++;
    end
    chk("nom_pma_cycles", n_pma, PMA);
    chk("nom_rpb_cycles", n_rpb, RPB);
    soft_err = '0;
    channel_up = '1;
    tick();
    chk("nom_ready", 32'(link_ready), 1);
    chk("nom_retry", 32'(retry_cnt), 0);

    // Soft-error saturation and clear priority.
    soft_err = 2'b01;
    for (int c = 0; c < 20; c++) begin
      rand_lanes();
      tick();
    end
    chk("soft_sat", 32'(soft_err_cnt[0]), SAT);
    err_clear = 1'b1;
    tick();
    chk("soft_clear_wins", 32'(soft_err_cnt[0]), 0);
    err_clear = 1'b0;
    soft_err = '0;

    // Link loss with a simultaneous hard error on channel 1.
    exp_h = (32'(hard_err_cnt[1]) < SAT) ? 32'(hard_err_cnt[1]) + 1 : SAT;
    channel_up = 2'b01;
    hard_err = 2'b10;
    tick();
    chk("loss_ready", 32'(link_ready), 0);
    chk("loss_state", 32'(state), 1);
    chk("loss_retry", 32'(retry_cnt), 1);
    chk("loss_hard1", 32'(hard_err_cnt[1]), exp_h);
    hard_err = '0;
    channel_up = '1;
    soft_err = 2'b01;
    for (int c = 0; c < 5; c++) tick();
    chk("soft_in_pma", 32'(soft_err_cnt[0]), 0);
    soft_err = '0;
    wait_model(4, 40, "relink_ready");

    // Timeouts exhaust the retries and land in FAIL.
    enable = 1'b0;
    tick();
    chk("dis_idle", 32'(state), 0);
    enable = 1'b1;
    channel_up = '0;
    n_wait = 0;
    for (int i = 0; i < 300 && m_st != 5; i++) begin
      rand_lanes();
      tick();
      if (state == 3'd3) n_wait++;
    end
    chk("fail_wait_cycles", n_wait, 3 * UPT);
    chk("fail_flag", 32'(link_fail), 1);
    chk("fail_pma", 32'(pma_init), 1);
    chk("fail_retry", 32'(retry_cnt), RM);
    for (int c = 0; c < 4; c++) tick();
    enable = 1'b0;
    tick();
    chk("fail_exit_state", 32'(state), 0);
    chk("fail_exit_retry", 32'(retry_cnt), 0);

    // Disable while in RESET_PB.
    enable = 1'b1;
    wait_model(2, 20, "reach_rpb");
    enable = 1'b0;
    tick();
    chk("rpb_dis_state", 32'(state), 0);
    chk("rpb_dis_pma", 32'(pma_init), 1);
    chk("rpb_dis_rpb", 32'(reset_pb), 1);

    // Asynchronous reset while READY, observed before any clock edge.
    enable = 1'b1;
    channel_up = '1;
    soft_err = 2'b11;
    wait_model(4, 40, "reach_ready");
    tick();
    soft_err = '0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_ready", 32'(link_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();

    // Randomized operation against the model.
    for (int i = 0; i < 600; i++) begin
      enable     = ($urandom_range(31) != 0);
      channel_up = ($urandom_range(3) != 0) ? '1 : 2'($urandom);
      hard_err   = ($urandom_range(40) == 0) ? 2'($urandom) : '0;
      soft_err   = 2'($urandom);
      err_clear  = ($urandom_range(50) == 0);
      rand_lanes();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aurora_link_supervisor.md
# aurora_link_supervisor

Multi-channel Aurora 64b66b link bring-up and health supervisor.
- Drives the shared `pma_init`/`reset_pb` reset sequence.
- Waits for every channel to come up, with a timeout.
- On timeout, hard error or channel loss, restarts the sequence with bounded retries.
- Keeps saturating per-channel soft/hard error counters.
- Sits in the `init_clk` domain beside the Aurora wrapper and replaces its fixed reset logic with a supervised, parametrised one.

## Interface
Parameters:
- `CH_CNT`, 3, number of Aurora channels
- `LANE_CNT`, 2, lanes per channel
- `PMA_INIT_TICKS`, 1024, cycles `pma_init` is held high per attempt (≥1)
- `RESET_PB_TICKS`, 128, cycles `reset_pb` stays high after `pma_init` release (≥1)
- `UP_TIMEOUT`, 1048576, cycles allowed in WAIT_UP before a retry (≥1)
- `RETRY_MAX`, 7, retries before FAIL; 0 = retry forever
- `ERR_CNT_W`, 16, width of each error counter

Ports:
- `clk` in 1: free-running init clock.
- `reset` in 1: asynchronous, active-high reset. One clock only.
- `enable` in 1: 1 runs the supervisor; 0 forces IDLE.
- `channel_up` in [CH_CNT]: per-channel link up. Already synchronised to `clk` by the instantiator, as are all status inputs.
- `lane_up` in [CH_CNT][LANE_CNT]: per-lane up, used for the status output only.
- `hard_err` in [CH_CNT]: Aurora hard error.
- `soft_err` in [CH_CNT]: Aurora soft error.
- `err_clear` in 1: synchronous clear of all error counters.
- `pma_init` out 1: GT PMA reset to all Aurora instances.
- `reset_pb` out 1: Aurora system reset.
- `link_ready` out 1: all channels up in READY.
- `link_fail` out 1: retries exhausted.
- `state` out 3: current FSM state encoding.
- `retry_cnt` out 8: retries since leaving IDLE, saturating at 255.
- `lanes_up` out 1: AND of all `lane_up`, registered.
- `soft_err_cnt` out [CH_CNT][ERR_CNT_W]: saturating soft-error cycle count.
- `hard_err_cnt` out [CH_CNT][ERR_CNT_W]: saturating hard-error cycle count.

## Operation
FSM states: IDLE=0, PMA_INIT=1, RESET_PB=2, WAIT_UP=3, READY=4, FAIL=5.

- **IDLE**
  - Outputs: `pma_init`=1, `reset_pb`=1; `retry_cnt` and timer cleared.
  - `enable`=1 → PMA_INIT.
- **PMA_INIT**
  - Outputs: `pma_init`=1, `reset_pb`=1.
  - After exactly `PMA_INIT_TICKS` cycles in this state → RESET_PB.
- **RESET_PB**
  - Outputs: `pma_init`=0, `reset_pb`=1.
  - After exactly `RESET_PB_TICKS` cycles → WAIT_UP.
- **WAIT_UP**
  - Outputs: both resets 0.
  - `&channel_up` → READY.
  - Else any `hard_err`, or `UP_TIMEOUT` cycles elapsed → retry.
  - If `&channel_up` and `hard_err` occur in the same cycle, retry wins.
- **READY**
  - Outputs: `link_ready`=1.
  - Any `channel_up` low or any `hard_err` → retry.
- **Retry decision**
  - If `RETRY_MAX`≠0 and `retry_cnt`==`RETRY_MAX` → FAIL.
  - Else increment `retry_cnt` (saturating) → PMA_INIT with the timer reloaded.
- **FAIL**
  - Outputs: `pma_init`=1, `reset_pb`=1, `link_fail`=1.
  - Held until `enable`=0.
- `enable`=0 in any state → IDLE next edge. This has priority over all other transitions.
- Error counters:
  - Count only in WAIT_UP and READY, adding 1 per cycle with the input high.
  - Saturate at all-ones.
  - `err_clear` wins over a simultaneous increment, leaving the counter at 0.
  - Counters are not cleared by retries or IDLE.

## Timing
- Reset values: state IDLE, `pma_init`=1, `reset_pb`=1, `link_ready`=0, `link_fail`=0, `retry_cnt`=0, `lanes_up`=0, all counters 0.
- All outputs are registered. Reset/ready/fail outputs are decoded from next-state, so they change on the same edge as `state`.
- Status-to-action latency is 1 cycle: a condition sampled at edge k is reflected on the outputs after edge k.
- Timer width: `$clog2` of the maximum of the three tick parameters, plus 1. Timer reloads on every state entry.
- Asynchronous `reset` mid-operation returns to the reset values immediately; there is no partial sequence.

## Structure
- Package `aurora_sup_pkg`: `state_t` enum (3-bit, values as above) and a function computing the timer width.
- Sub-module `aurora_sup_err_cnt`: single saturating counter with `inc`/`clr`/`en`, parameter `W`, instantiated 2×`CH_CNT`.

## Test plan
All scenarios use `CH_CNT`=2, `PMA_INIT_TICKS`=8, `RESET_PB_TICKS`=4, `UP_TIMEOUT`=32, `RETRY_MAX`=2, `ERR_CNT_W`=4.

- **Nominal bring-up.** Reset, then `enable`=1; `channel_up`=2'b11 from cycle 20.
  - `pma_init` is high 8 cycles after entry, then `reset_pb` high 4 more.
  - `link_ready`=1 one cycle after `channel_up` is seen in WAIT_UP; `retry_cnt`=0.
- **Timeout and fail.** `channel_up` held 0.
  - 32 cycles in WAIT_UP, then the sequence restarts twice (`retry_cnt` 1, 2).
  - The third timeout gives FAIL with `link_fail`=1 and `pma_init`=1.
  - `enable`=0 → IDLE with `retry_cnt`=0.
- **Link loss.** In READY, drop `channel_up[1]` for 1 cycle.
  - `link_ready`=0 next cycle, state PMA_INIT, `retry_cnt`=1.
  - A simultaneous `hard_err` also increments `hard_err_cnt[1]`.
- **Counter saturation and clear.** `soft_err[0]` held high 20 cycles in READY.
  - `soft_err_cnt[0]`=15.
  - `err_clear` together with `soft_err`=1 gives 0.
  - `soft_err` during PMA_INIT leaves the counter unchanged.
- **Disable and reset mid-sequence.**
  - `enable`=0 in RESET_PB → IDLE with both resets 1 next cycle.
  - Async `reset` pulse in READY → all outputs at reset values without a clock edge.
